// File: rtl/div23_seq_ctrl.sv
// Sequential constant-divisor controller: walks the dividend MSB-first in CHUNK-bit
// digits, one remainder step per clock, with valid/ready handshakes on both sides.
module div23_seq_ctrl #(
    parameter int W       = 32,
    parameter int CHUNK   = 3,
    parameter int DIVISOR = 23,
    parameter int REM_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_dividend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_quotient,
    output logic [REM_W-1:0] out_remainder,
    output logic             busy
);

    localparam int STEPS = (W + CHUNK - 1) / CHUNK;
    localparam int SH_W  = STEPS * CHUNK;
    localparam int V_W   = REM_W + CHUNK;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [V_W-1:0]   DIV_V     = V_W'(DIVISOR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SH_W-1:0]  shift_q;
    logic [REM_W-1:0] rem_q;
    logic [W-1:0]     quo_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [CHUNK-1:0] digit;
    logic [V_W-1:0]   v;
    logic [CHUNK-1:0] qdigit_d;
    logic [REM_W-1:0] rem_d;
    logic [SH_W-1:0]  shift_d;
    logic [W-1:0]     quo_d;

    // One remainder step; with a constant divisor this folds into small lookup tables.
    assign digit    = shift_q[SH_W-1 -: CHUNK];
    assign v        = {rem_q, digit};
    assign qdigit_d = CHUNK'(v / DIV_V);
    assign rem_d    = REM_W'(v % DIV_V);
    assign shift_d  = {shift_q[SH_W-CHUNK-1:0], {CHUNK{1'b0}}};
    // Quotient bits above W are always zero (padding digits), so they are not stored.
    assign quo_d    = {quo_q[W-CHUNK-1:0], qdigit_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q    <= SH_W'(in_dividend);
                        rem_q      <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    shift_q <= shift_d;
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q;

endmodule

// File: tb/tb_div23_seq_ctrl.sv
// Scoreboard bench for div23_seq_ctrl: directed corner cases, backpressure,
// mid-run reset, then random dividends with random result stalls.
module tb_div23_seq_ctrl;

    localparam int W       = 32;
    localparam int REM_W   = 5;
    localparam int DIVISOR = 23;
    localparam int STEPS   = 11;
    localparam int N_RAND  = 2500;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_dividend;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_quotient;
    logic [REM_W-1:0] out_remainder;
    logic             busy;

    div23_seq_ctrl #(.W(W), .CHUNK(3), .DIVISOR(DIVISOR), .REM_W(REM_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .busy         (busy)
    );

    typedef struct {
        logic [W-1:0]     q;
        logic [REM_W-1:0] r;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   neg_cyc = 0;
    int   ready_mode = 1;   // 0: random stalls, 1: always ready, 2: hold off

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result consumer
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks handshake invariants, latency, hold under stall, and results
    logic             prev_valid = 1'b0;
    logic [W-1:0]     prev_q = '0;
    logic [REM_W-1:0] prev_r = '0;

    always @(negedge clk) begin
        neg_cyc++;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            chk("busy_vs_ready", busy, !in_ready);
            chk("ready_when_idle", in_ready, sb.size() == 0);
            if (out_valid && !prev_valid) begin
                chk("valid_expected", sb.size() != 0, 1);
                if (sb.size() != 0)
                    chk("latency", neg_cyc - sb[0].acc, STEPS + 1);
            end
            if (out_valid && prev_valid) begin
                chk("hold_quotient", out_quotient, prev_q);
                chk("hold_remainder", out_remainder, prev_r);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                chk("quotient", out_quotient, sb[0].q);
                chk("remainder", out_remainder, sb[0].r);
                $display("result q=%0d r=%0d", out_quotient, out_remainder);
                void'(sb.pop_front());
            end
            prev_valid = out_valid;
            prev_q     = out_quotient;
            prev_r     = out_remainder;
        end
    end

    task automatic send(input logic [W-1:0] x);
        logic rdy;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        in_dividend = x;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                e.q   = x / DIVISOR;
                e.r   = REM_W'(x % DIVISOR);
                e.acc = neg_cyc;
                sb.push_back(e);
                $display("send x=%0d expect q=%0d r=%0d", x, e.q, e.r);
                #1;
                in_valid    = 1'b0;
                in_dividend = $urandom;
                return;
            end
        end
        chk("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready && sb.size() == 0) return;
        end
        chk("idle_timeout", in_ready, 1);
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] q, input logic [REM_W-1:0] r);
        send(x);
        wait_idle();
        chk("dir_quotient_idle", out_quotient, q);
        chk("dir_remainder_idle", out_remainder, r);
    endtask

    initial begin
        logic [W-1:0] x;
        int found;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", out_quotient, 0);
        chk("rst_remainder", out_remainder, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        ready_mode = 1;
        directed(32'd0, 32'd0, 5'd0);
        directed(32'd22, 32'd0, 5'd22);
        directed(32'd23, 32'd1, 5'd0);
        directed(32'd1000000, 32'd43478, 5'd6);
        directed(32'hFFFF_FFFF, 32'd186737708, 5'd11);

        // Backpressure: result held for 20 cycles, then released
        ready_mode = 2;
        send(32'h1234_5678);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        chk("bp_valid_seen", out_valid, 1);
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid_held", out_valid, 1);
            chk("bp_ready_low", in_ready, 0);
        end
        ready_mode = 1;
        repeat (2) @(negedge clk);
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_quotient_kept", out_quotient, 32'h1234_5678 / DIVISOR);

        // Reset in the middle of a division
        send(32'hDEAD_BEEF);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_quotient", out_quotient, 0);
        chk("mid_rst_remainder", out_remainder, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        directed(32'd46, 32'd2, 5'd0);

        // Random dividends with random result stalls
        ready_mode = 0;
        for (int n = 0; n < N_RAND; n++) begin
            case ($urandom_range(0, 9))
                0:       x = 32'hFFFF_FFFF - 32'($urandom_range(0, 30));
                1:       x = 32'($urandom_range(0, 60));
                default: x = $urandom;
            endcase
            send(x);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        ready_mode = 1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
